flash_seq: RTL and testbench

Bus-cycle sequencer for the NAND flash port. It accepts one page-level operation descriptor at a time (read page, program page, erase block) and generates the command, address, data and ready/busy wait phases on the flash pins. Page data streams through a byte handshake to and from the page buffer. It sits between the top-level NFC command decoder and the flash pins; tristate muxing of F_IO is done outside.

---
 rtl/flash_seq.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_flash_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flash_seq.sv
// flash_seq - NAND flash bus-cycle sequencer.
//
// Takes one page-level operation at a time and drives the command, address,
// data and ready/busy phases on the flash pins. It supports read page,
// program page and erase block. Page data moves through a byte handshake
// to and from the page buffer. F_IO tristate muxing is done outside.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   op_valid/op_ready     operation request handshake (ready only in IDLE)
//   op_code, op_row       00 read, 01 program, 10 erase, 11 reserved; row address
//   wd_valid/wd_data/wd_ready  program data bytes from the page buffer
//   rd_valid, rd_data     read data bytes (one-clock pulse, no backpressure)
//   done, err, busy       completion pulse, result code, operation in flight
//   F_IO_out/F_IO_oe/F_IO_in   flash data bus drive value, enable, sample
//   F_CLE, F_ALE, F_WEN, F_REN flash strobes (WEN/REN active-low)
//   F_RB                  flash ready (1) / busy (0)
module flash_seq #(
  parameter int PAGE_BYTES = 512,
  parameter int ROW_W      = 17,
  parameter int WB_CYC     = 2,
  parameter int TO_CYC     = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [ROW_W-1:0] op_row,
  input  logic             wd_valid,
  input  logic [7:0]       wd_data,
  output logic             wd_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic [1:0]       err,
  output logic             busy,
  output logic [7:0]       F_IO_out,
  output logic             F_IO_oe,
  input  logic [7:0]       F_IO_in,
  output logic             F_CLE,
  output logic             F_ALE,
  output logic             F_WEN,
  output logic             F_REN,
  input  logic             F_RB
);

  localparam int CNT_MAX = (PAGE_BYTES > TO_CYC) ? PAGE_BYTES : TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PAGE_LAST = CNT_W'(PAGE_BYTES);
  localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WB_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_BAD   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA_W, ST_CMD2, ST_WB,
    ST_WAIT_RB, ST_DATA_R, ST_STAT_CMD, ST_STAT_RD, ST_DONE
  } state_e;

  // Every bus cycle is two clocks: A (strobe active) and B (strobe released).
  typedef enum logic {PH_A, PH_B} ph_e;

  state_e           state_q, state_d;
  ph_e              ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             stat_q, stat_d;
  logic [7:0]       io_q, io_d;
  logic             oe_q, oe_d, cle_q, cle_d, ale_q, ale_d;
  logic             wen_q, wen_d, ren_q, ren_d;
  logic             rvld_q, rvld_d, done_q, done_d, busy_q, busy_d, wrdy_q, wrdy_d;
  logic [7:0]       rdat_q, rdat_d;
  logic [1:0]       err_q, err_d;
  logic             wr_st, rd_st;
  logic [1:0]       aidx_nxt, aidx_last;

  function automatic logic [7:0] first_cmd(input logic [1:0] op);
    case (op)
      OP_PROG:  return 8'h80;
      OP_ERASE: return 8'h60;
      default:  return 8'h00;
    endcase
  endfunction

  // Erase has no column byte, so its address index is shifted by one.
  function automatic logic [7:0] addr_byte(input logic [1:0] op,
                                           input logic [ROW_W-1:0] row,
                                           input logic [1:0] idx);
    logic [23:0] row24;
    logic [1:0]  sel;
    row24 = 24'(row);
    sel   = (op == OP_ERASE) ? idx + 2'd1 : idx;
    case (sel)
      2'd0:    return 8'h00;
      2'd1:    return row24[7:0];
      2'd2:    return row24[15:8];
      default: return row24[23:16];
    endcase
  endfunction

  assign aidx_nxt  = cnt_q[1:0] + 2'd1;
  assign aidx_last = (op_q == OP_ERASE) ? 2'd2 : 2'd3;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    row_d   = row_q;
    stat_d  = stat_q;
    io_d    = io_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    rvld_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d  = op_code;
          row_d = op_row;
          err_d = 2'b00;
          cnt_d = '0;
          ph_d  = PH_A;
          if (op_code == OP_BAD) begin
            state_d = ST_DONE;
            err_d   = 2'b11;
          end else begin
            state_d = ST_CMD;
            io_d    = first_cmd(op_code);
          end
        end
      end
      ST_CMD: begin
        if (ph_q == PH_A) begin
          ph_d = PH_B;
        end else begin
          state_d = ST_ADDR;
          ph_d    = PH_A;
          cnt_d   = '0;
          io_d    = addr_byte(op_q, row_q, 2'd0);
        end
      end
      ST_ADDR: begin
        if (ph_q == PH_A) begin
          ph_d = PH_B;
        end else if (cnt_q[1:0] == aidx_last) begin
          cnt_d = '0;
          case (op_q)
            OP_READ: state_d = ST_WB;
            OP_PROG: begin
              // Enter with the slot empty: WEN stays high, wd_ready rises.
              state_d = ST_DATA_W;
              ph_d    = PH_B;
            end
            default: begin
              state_d = ST_CMD2;
              ph_d    = PH_A;
              io_d    = 8'hD0;
            end
          endcase
        end else begin
          ph_d  = PH_A;
          cnt_d = cnt_q + CNT_ONE;
          io_d  = addr_byte(op_q, row_q, aidx_nxt);
        end
      end
      ST_DATA_W: begin
        if (ph_q == PH_A) begin
          ph_d = PH_B;
        end else if (cnt_q == PAGE_LAST) begin
          state_d = ST_CMD2;
          ph_d    = PH_A;
          io_d    = 8'h10;
        end else if (wd_valid && wrdy_q) begin
          ph_d  = PH_A;
          cnt_d = cnt_q + CNT_ONE;
          io_d  = wd_data;
        end
      end
      ST_CMD2: begin
        if (ph_q == PH_A) begin
          ph_d = PH_B;
        end else begin
          state_d = ST_WB;
          cnt_d   = '0;
        end
      end
      ST_WB: begin
        if (cnt_q == WB_LAST) begin
          state_d = ST_WAIT_RB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // F_RB is used as-is; it is assumed synchronous to clk at this port.
      ST_WAIT_RB: begin
        if (F_RB) begin
          ph_d  = PH_A;
          cnt_d = '0;
          if (op_q == OP_READ) begin
            state_d = ST_DATA_R;
          end else begin
            state_d = ST_STAT_CMD;
            io_d    = 8'h70;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA_R: begin
        if (ph_q == PH_A) begin
          ph_d   = PH_B;
          rdat_d = F_IO_in;
          rvld_d = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
        end else if (cnt_q == PAGE_LAST) begin
          state_d = ST_DONE;
        end else begin
          ph_d = PH_A;
        end
      end
      ST_STAT_CMD: begin
        if (ph_q == PH_A) begin
          ph_d = PH_B;
        end else begin
          state_d = ST_STAT_RD;
          ph_d    = PH_A;
        end
      end
      ST_STAT_RD: begin
        if (ph_q == PH_A) begin
          ph_d   = PH_B;
          stat_d = F_IO_in[0];
        end else begin
          state_d = ST_DONE;
          err_d   = {1'b0, stat_q};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so that every pin is a flop.
  assign wr_st  = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_DATA_W) ||
                  (state_d == ST_CMD2) || (state_d == ST_STAT_CMD);
  assign rd_st  = (state_d == ST_DATA_R) || (state_d == ST_STAT_RD);
  assign oe_d   = wr_st;
  assign cle_d  = (state_d == ST_CMD) || (state_d == ST_CMD2) || (state_d == ST_STAT_CMD);
  assign ale_d  = (state_d == ST_ADDR);
  assign wen_d  = !(wr_st && (ph_d == PH_A));
  assign ren_d  = !(rd_st && (ph_d == PH_A));
  assign done_d = (state_d == ST_DONE);
  assign busy_d = (state_d != ST_IDLE);
  assign wrdy_d = (state_d == ST_DATA_W) && (ph_d == PH_B) && (cnt_d != PAGE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ph_q    <= PH_A;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      io_q    <= 8'h00;
      oe_q    <= 1'b0;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      wen_q   <= 1'b1;
      ren_q   <= 1'b1;
      rvld_q  <= 1'b0;
      rdat_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
      wrdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      wrdy_q  <= wrdy_d;
    end
  end

  // Row and status bit are always written before they are read.
  always_ff @(posedge clk) begin
    row_q  <= row_d;
    stat_q <= stat_d;
  end

  assign op_ready = (state_q == ST_IDLE);
  assign wd_ready = wrdy_q;
  assign rd_valid = rvld_q;
  assign rd_data  = rdat_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign F_IO_out = io_q;
  assign F_IO_oe  = oe_q;
  assign F_CLE    = cle_q;
  assign F_ALE    = ale_q;
  assign F_WEN    = wen_q;
  assign F_REN    = ren_q;

endmodule

// File: tb/tb_flash_seq.sv
// tb_flash_seq - directed bench for flash_seq with a small flash pin model.
module tb_flash_seq;
  localparam int PB     = 512;
  localparam int RW     = 17;
  localparam int RB_LOW = 13;
  localparam logic [31:0] RST_EXP = {5'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00,
                                     1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid, op_ready;
  logic [1:0]    op_code;
  logic [RW-1:0] op_row;
  logic          wd_valid = 1'b0;
  logic [7:0]    wd_data = 8'h00;
  logic          wd_ready, rd_valid, done, busy;
  logic [7:0]    rd_data;
  logic [1:0]    err;
  logic [7:0]    F_IO_out;
  logic [7:0]    F_IO_in = 8'h00;
  logic          F_IO_oe, F_CLE, F_ALE, F_WEN, F_REN;
  logic          F_RB = 1'b1;

  flash_seq #(.PAGE_BYTES(PB), .ROW_W(RW), .WB_CYC(2), .TO_CYC(20)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_row(op_row), .wd_valid(wd_valid), .wd_data(wd_data),
    .wd_ready(wd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
    .err(err), .busy(busy), .F_IO_out(F_IO_out), .F_IO_oe(F_IO_oe),
    .F_IO_in(F_IO_in), .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN),
    .F_REN(F_REN), .F_RB(F_RB));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [31:0] t;
    t = k * 37 + 5;
    return t[7:0];
  endfunction

  function automatic logic [31:0] out_vec();
    return {5'b0, F_CLE, F_ALE, F_WEN, F_REN, F_IO_oe, F_IO_out,
            rd_valid, rd_data, done, err, busy, wd_ready};
  endfunction

  // Flash model and bus monitor, all on the falling edge.
  logic [9:0] wlog [0:1023];
  int         wn = 0, ren_n = 0, rd_k = 0, rd_bad = 0, gap_bad = 0, proto_bad = 0;
  int         hs_n = 0, cyc = 0, last_rd = -100, rb_cnt = 0;
  logic [7:0] last_cmd = 8'h00, exp_rd = 8'h00;
  logic [7:0] stat_val = 8'h00;
  logic       rb_stuck = 1'b0;
  logic       wd_en = 1'b0;
  int         hs_base = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!F_WEN) begin
      if (wn < 1024) wlog[wn] = {F_CLE, F_ALE, F_IO_out};
      wn++;
      if (F_CLE) last_cmd = F_IO_out;
      if (!F_IO_oe) proto_bad++;
    end
    if (!F_REN) begin
      F_IO_in = (last_cmd == 8'h70) ? stat_val : pat(ren_n);
      exp_rd  = F_IO_in;
      ren_n++;
      if (F_IO_oe || !F_WEN) proto_bad++;
    end
    if (rd_valid) begin
      if (rd_data !== exp_rd) rd_bad++;
      if (cyc - last_rd < 2) gap_bad++;
      last_rd = cyc;
      rd_k++;
    end
    if (!F_WEN) rb_cnt = RB_LOW;
    else if (rb_cnt != 0) rb_cnt--;
    F_RB = (rb_cnt == 0) && !rb_stuck;
    if (wd_valid && wd_ready) hs_n++;
  end

  // Page buffer: data byte n is n[7:0]; valid drops every 7th clock.
  int wcyc = 0;
  always begin
    @(posedge clk);
    #1;
    wcyc++;
    wd_valid = wd_en && (wcyc % 7 != 0);
    wd_data  = 8'(hs_n - hs_base);
  end

  task automatic run_op(input logic [1:0] code, input logic [RW-1:0] row, output int lat);
    op_valid = 1'b1;
    op_code  = code;
    op_row   = row;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 2'b11;
    op_row   = '1;
    chk("busy_after_accept", busy, 1);
    lat = 1;
    while (!done && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic after_done(input string tag, input logic [1:0] exp_err);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {done, op_ready, busy, err}, {1'b0, 1'b1, 1'b0, exp_err});
  endtask

  initial begin
    int lat, b_w, b_r, b_rd, bad, dn;
    logic [9:0] er_exp [0:5];
    er_exp[0] = {2'b10, 8'h60}; er_exp[1] = {2'b01, 8'h45}; er_exp[2] = {2'b01, 8'h23};
    er_exp[3] = {2'b01, 8'h01}; er_exp[4] = {2'b10, 8'hD0}; er_exp[5] = {2'b10, 8'h70};

    rst = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_row = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), RST_EXP);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_op_ready", op_ready, 1);

    // Erase, row 1_2345h, status ok
    b_w = wn; b_r = ren_n; stat_val = 8'h00;
    run_op(2'b10, 17'h12345, lat);
    chk("er_latency", lat, 27);
    chk("er_done_err", {done, err}, {1'b1, 2'b00});
    chk("er_wcycles", wn - b_w, 6);
    chk("er_ren", ren_n - b_r, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("er_w%0d", i), wlog[b_w + i], er_exp[i]);
    after_done("er", 2'b00);

    // Program 512 bytes, status fail
    b_w = wn; hs_base = hs_n; stat_val = 8'h01; wd_en = 1'b1;
    run_op(2'b01, 17'h000A5, lat);
    wd_en = 1'b0;
    chk("pg_done_err", {done, err}, {1'b1, 2'b01});
    chk("pg_wcycles", wn - b_w, 519);
    chk("pg_handshakes", hs_n - hs_base, 512);
    chk("pg_cmd", wlog[b_w], {2'b10, 8'h80});
    chk("pg_col", wlog[b_w + 1], {2'b01, 8'h00});
    chk("pg_row0", wlog[b_w + 2], {2'b01, 8'hA5});
    chk("pg_row1", wlog[b_w + 3], {2'b01, 8'h00});
    chk("pg_row2", wlog[b_w + 4], {2'b01, 8'h00});
    bad = 0;
    for (int i = 0; i < 512; i++) if (wlog[b_w + 5 + i] !== {2'b00, 8'(i)}) bad++;
    chk("pg_data_bad", bad, 0);
    chk("pg_cmd2", wlog[b_w + 517], {2'b10, 8'h10});
    chk("pg_stat", wlog[b_w + 518], {2'b10, 8'h70});
    after_done("pg", 2'b01);

    // Read page 0
    b_w = wn; b_r = ren_n; b_rd = rd_k;
    run_op(2'b00, '0, lat);
    chk("rd_latency", lat, 1047);
    chk("rd_done_err", {done, err}, {1'b1, 2'b00});
    chk("rd_wcycles", wn - b_w, 5);
    chk("rd_cmd", wlog[b_w], {2'b10, 8'h00});
    for (int i = 1; i < 5; i++) chk($sformatf("rd_addr%0d", i), wlog[b_w + i], {2'b01, 8'h00});
    chk("rd_ren", ren_n - b_r, 512);
    chk("rd_valid_cnt", rd_k - b_rd, 512);
    chk("rd_data_bad", rd_bad, 0);
    chk("rd_gap_bad", gap_bad, 0);
    after_done("rd", 2'b00);

    // RB timeout during erase
    rb_stuck = 1'b1; b_w = wn; b_r = ren_n;
    run_op(2'b10, 17'h00001, lat);
    rb_stuck = 1'b0;
    chk("to_latency", lat, 33);
    chk("to_done_err", {done, err}, {1'b1, 2'b10});
    chk("to_wcycles", wn - b_w, 5);
    chk("to_last_cmd", wlog[b_w + 4], {2'b10, 8'hD0});
    chk("to_ren", ren_n - b_r, 0);
    after_done("to", 2'b10);

    // Reserved opcode
    b_w = wn; b_r = ren_n;
    run_op(2'b11, 17'h1FFFF, lat);
    chk("bad_latency", lat, 1);
    chk("bad_done_err", {done, err}, {1'b1, 2'b11});
    chk("bad_strobes", (wn - b_w) + (ren_n - b_r), 0);
    after_done("bad", 2'b11);

    // Reset in the middle of a page read
    op_valid = 1'b1; op_code = 2'b00; op_row = 17'h5;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", out_vec(), RST_EXP);
    @(negedge clk) rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_op_ready", op_ready, 1);
    chk("protocol_bad", proto_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
